// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide sequencer owning the HI/LO registers.
// Optional macro MULDIV_EARLY_EXIT_EN ends a multiply once no multiplier bits remain.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             divE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, sreg, opnd;
  logic [CNT_W-1:0] count;
  logic             op_div, neg_result, neg_rem, div_zero;

  logic             start_ok, trial_ok;
  logic [WIDTH-1:0] abs_a, abs_b, acc_step, sreg_step, fix_hi, fix_lo;
  logic [WIDTH:0]   add_a, add_b, sum;
  logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0] exit_mask;
  logic [CNT_W-1:0] skip;
`endif

  assign start_ok = startE & ~abort;
  assign abs_a = (signedE && srcaE[WIDTH-1]) ? (~srcaE + 1'b1) : srcaE;
  assign abs_b = (signedE && srcbE[WIDTH-1]) ? (~srcbE + 1'b1) : srcbE;

  // One shared adder: conditional add for multiply, trial subtract for divide.
  always_comb begin
    add_a = op_div ? {acc, sreg[WIDTH-1]} : {1'b0, acc};
    add_b = op_div ? ~{1'b0, opnd} : (sreg[0] ? {1'b0, opnd} : '0);
    sum   = add_a + add_b + {{WIDTH{1'b0}}, op_div};
    trial_ok = ~sum[WIDTH];
    if (op_div) begin
      acc_step  = trial_ok ? sum[WIDTH-1:0] : {acc[WIDTH-2:0], sreg[WIDTH-1]};
      sreg_step = {sreg[WIDTH-2:0], trial_ok};
    end else begin
      acc_step  = sum[WIDTH:1];
      sreg_step = {sum[0], sreg[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = {acc, sreg};
`ifdef MULDIV_EARLY_EXIT_EN
    exit_mask = ({WIDTH{1'b1}} >> count) >> 1;
    skip      = -count;
    prod      = prod >> skip;
`endif
    if (neg_result) prod = ~prod + 1'b1;
    if (div_zero) begin
      fix_hi = acc;
      fix_lo = '1;
    end else if (op_div) begin
      fix_hi = neg_rem ? (~acc + 1'b1) : acc;
      fix_lo = neg_result ? (~sreg + 1'b1) : sreg;
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (divE && srcbE == '0) state_next = FIXUP;
`ifdef MULDIV_EARLY_EXIT_EN
          else if (!divE && srcbE == '0) state_next = FIXUP;
`endif
          else state_next = RUN;
        end
      end
      RUN: begin
        if (abort) state_next = IDLE;
        else if (count == CNT_W'(WIDTH-1)) state_next = FIXUP;
`ifdef MULDIV_EARLY_EXIT_EN
        else if (!op_div && (sreg_step & exit_mask) == '0) state_next = FIXUP;
`endif
      end
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divide-by-zero parks the raw dividend in acc so FIXUP can copy it to HI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0; sreg <= '0; opnd <= '0; count <= '0;
      op_div <= 1'b0; neg_result <= 1'b0; neg_rem <= 1'b0; div_zero <= 1'b0;
      hi <= '0; lo <= '0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            op_div     <= divE;
            opnd       <= divE ? abs_b : abs_a;
            sreg       <= divE ? abs_a : abs_b;
            acc        <= (divE && srcbE == '0) ? srcaE : '0;
            div_zero   <= divE && (srcbE == '0);
            neg_result <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            neg_rem    <= signedE & srcaE[WIDTH-1];
            count      <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            acc   <= acc_step;
            sreg  <= sreg_step;
            count <= count + 1'b1;
          end
        end
        FIXUP: begin
          if (!abort) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table with a result
// scoreboard, plus abort, restart, start+abort and async-reset sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        startE, divE, signedE, abort;
  logic [31:0] srcaE, srcbE;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic        div;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[14];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .startE(startE), .divE(divE), .signedE(signedE),
    .srcaE(srcaE), .srcbE(srcbE), .abort(abort),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int expLatency(input logic div, input logic sgn, input logic [31:0] b);
    logic [31:0] mag;
    mag = (sgn && b[31]) ? (~b + 32'd1) : b;
    if (div) return (b == 0) ? 1 : 33;
`ifdef MULDIV_EARLY_EXIT_EN
    if (mag == 0) return 1;
    for (int i = 31; i >= 0; i--)
      if (mag[i]) return i + 2;
    return 1;
`else
    return (mag == mag) ? 33 : 33;
`endif
  endfunction

  // Launch one operation; optionally abort or re-issue start at a cycle offset.
  task automatic applyStimulus(input vec_t v, input int abort_at, input int restart_at);
    int   n;
    int   busy_cnt;
    int   done_seen;
    bit   got;
    exp_t e;
    @(posedge clk); #1;
    startE = 1'b1; divE = v.div; signedE = v.sgn; srcaE = v.a; srcbE = v.b;
    if (abort_at < 0) sb.push_back('{v.exp_hi, v.exp_lo, expLatency(v.div, v.sgn, v.b)});
    @(posedge clk); #1;
    startE = 1'b0;
    n = 0; busy_cnt = busy ? 1 : 0; done_seen = 0; got = 1'b0;
    while (!got && n < 60) begin
      if (n == abort_at) abort = 1'b1;
      if (n == restart_at) begin
        startE = 1'b1; divE = 1'b1; signedE = 1'b0; srcaE = 32'h9; srcbE = 32'h0;
      end
      @(posedge clk); #1;
      n++;
      abort = 1'b0; startE = 1'b0;
      if (busy) busy_cnt++;
      if (n == abort_at + 1) checkOutput("busy low after abort", busy, 1'b0);
      if (done) begin
        done_seen++;
        checkOutput("done while busy", busy, 1'b0);
        if (abort_at < 0) got = 1'b1;
      end
      if (abort_at >= 0 && n >= 45) n = 60;
    end
    if (abort_at >= 0) begin
      checkOutput("no done after abort", 64'(done_seen), 64'd0);
      checkOutput("hi held after abort", hi, last_hi);
      checkOutput("lo held after abort", lo, last_lo);
    end else if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL done timeout: got no done, expected done within 60 cycles");
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      checkOutput("hi", hi, e.hi);
      checkOutput("lo", lo, e.lo);
      checkOutput("latency", 64'(n), 64'(e.lat));
      checkOutput("busy cycles", 64'(busy_cnt), 64'(e.lat));
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  initial begin
    int abort_cycle;
    int restart_cycle;
    vec_t v;
`ifdef MULDIV_EARLY_EXIT_EN
    abort_cycle = 2; restart_cycle = 2;
`else
    abort_cycle = 10; restart_cycle = 5;
`endif
    reset = 1'b1; startE = 1'b0; divE = 1'b0; signedE = 1'b0; abort = 1'b0;
    srcaE = '0; srcbE = '0;

    //             div   sgn   a             b             exp_hi        exp_lo
    vecs[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{1'b1, 1'b0, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[4]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{1'b0, 1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[7]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[9]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[11] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[12] = '{1'b0, 1'b1, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000};
    vecs[13] = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};

    #12;
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], -1, -1);

    $display("[TB] abort sequence");
    v = '{1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 32'd25};
    applyStimulus(v, abort_cycle, -1);

    $display("[TB] restart-while-busy sequence");
    applyStimulus(v, -1, restart_cycle);

    $display("[TB] start with abort in idle");
    @(posedge clk); #1;
    startE = 1'b1; abort = 1'b1; divE = 1'b1; signedE = 1'b0; srcaE = 32'd50; srcbE = 32'd0;
    @(posedge clk); #1;
    startE = 1'b0; abort = 1'b0;
    checkOutput("start suppressed busy", busy, 1'b0);
    @(posedge clk); #1;
    checkOutput("start suppressed done", done, 1'b0);

    $display("[TB] async reset mid-run");
    @(posedge clk); #1;
    startE = 1'b1; divE = 1'b1; signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd3;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("async reset busy", busy, 1'b0);
    checkOutput("async reset done", done, 1'b0);
    checkOutput("async reset hi", hi, 32'h0);
    checkOutput("async reset lo", lo, 32'h0);
    @(negedge clk); reset = 1'b0;
    last_hi = '0; last_lo = '0;
    applyStimulus(vecs[5], -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
